ecc_diag_codec_pipe: RTL and testbench

- Pipelined, multi-lane encoder/decoder for the team's 34-bit diagonal-parity code: 16 data bits plus 18 check bits per word.
- NUM_WORDS lanes are processed per beat, with valid/ready handshake on both sides.
- Decode mode corrects, flags and re-encodes each word (scrub). Saturating error counters support memory-scrub and telemetry paths.

---
 rtl/ecc_diag_pkg.sv | 47 ++++
 rtl/ecc_diag_lane.sv | 59 +++++
 rtl/ecc_diag_codec_pipe.sv | 144 ++++++++++++++
 tb/tb_ecc_diag_codec_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_diag_pkg.sv
// rtl/ecc_diag_pkg.sv - constants, region type and check/region functions for the 34-bit diagonal-parity code
package ecc_diag_pkg;

   localparam int CW_W   = 34;
   localparam int DATA_W = 16;
   localparam int CHK_W  = 18;

   typedef enum logic [1:0] {REG_NONE, REG_R1, REG_R2, REG_R3} region_e;

   // Element k (1..4) of group g is data[4g+4-k]; field bit 4g+3..4g holds {D,P,C[2],C[1]} of group g.
   function automatic logic [CHK_W-1:0] chk_field(input logic [DATA_W-1:0] d);
      logic [4:1]       e [4];
      logic [4:1]       p;
      logic [6:1]       dg;
      logic [CHK_W-1:0] f;
      for (int g = 0; g < 4; g++)
         for (int k = 1; k <= 4; k++)
            e[g][k] = d[4*g+4-k];
      for (int k = 1; k <= 4; k++)
         p[k] = e[0][k] ^ e[1][k] ^ e[2][k] ^ e[3][k];
      dg[1] = e[0][1] ^ e[1][2] ^ e[2][1] ^ e[3][2];
      dg[2] = e[1][1] ^ e[0][2] ^ e[2][2] ^ e[3][1];
      dg[3] = e[0][3] ^ e[1][4] ^ e[2][3] ^ e[3][4];
      dg[4] = e[1][3] ^ e[0][4] ^ e[2][4] ^ e[3][3];
      dg[5] = e[0][2] ^ e[1][3] ^ e[2][2] ^ e[3][3];
      dg[6] = e[1][2] ^ e[0][3] ^ e[2][3] ^ e[3][2];
      f = '0;
      for (int g = 0; g < 4; g++) begin
         f[4*g]   = e[g][2] ^ e[g][4];
         f[4*g+1] = e[g][1] ^ e[g][3];
         f[4*g+2] = p[g+1];
         f[4*g+3] = dg[g+1];
      end
      f[16] = dg[5];
      f[17] = dg[6];
      return f;
   endfunction

   // A region wins only with a strict majority; ties leave the word uncorrected.
   function automatic region_e region_sel(input logic [2:0] ta, input logic [2:0] tb, input logic [2:0] tc);
      if (ta > tb && ta > tc) return REG_R1;
      if (tb > ta && tb > tc) return REG_R2;
      if (tc > ta && tc > tb) return REG_R3;
      return REG_NONE;
   endfunction

endpackage

// File: rtl/ecc_diag_lane.sv
// rtl/ecc_diag_lane.sv - per-word syndrome (pre-S1) and correct/re-encode (pre-S2) combinational paths
module ecc_diag_lane
   import ecc_diag_pkg::*;
(
   input  logic [CW_W-1:0]   cw_i,
   output logic [CHK_W-1:0]  syn_o,
   output logic [2:0]        ta_o,
   output logic [2:0]        tb_o,
   output logic [2:0]        tc_o,
   input  logic              mode_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CHK_W-1:0]  syn_i,
   input  logic [2:0]        ta_i,
   input  logic [2:0]        tb_i,
   input  logic [2:0]        tc_i,
   output logic [CW_W-1:0]   cw_o,
   output logic              corr_o,
   output logic              uncorr_o
);

   logic [CHK_W-1:0]  s;
   region_e           region;
   logic [DATA_W-1:0] fixed;

   always_comb begin
      s     = cw_i[CW_W-1:DATA_W] ^ chk_field(cw_i[DATA_W-1:0]);
      syn_o = s;
      ta_o  = 3'(s[3])  + 3'(s[7])  + 3'(s[2])  + 3'(s[6]);
      tb_o  = 3'(s[11]) + 3'(s[15]) + 3'(s[10]) + 3'(s[14]);
      tc_o  = 3'(s[16]) + 3'(s[17]) + 3'(s[6])  + 3'(s[10]);
   end

   // Encode beats reuse the re-encode path with correction forced off.
   always_comb begin
      region = mode_i ? region_sel(ta_i, tb_i, tc_i) : REG_NONE;
      fixed  = data_i;
      for (int g = 0; g < 4; g++) begin
         case (region)
            REG_R1: begin
               fixed[4*g+3] = fixed[4*g+3] ^ syn_i[4*g+1];
               fixed[4*g+2] = fixed[4*g+2] ^ syn_i[4*g];
            end
            REG_R2: begin
               fixed[4*g+1] = fixed[4*g+1] ^ syn_i[4*g+1];
               fixed[4*g]   = fixed[4*g]   ^ syn_i[4*g];
            end
            REG_R3: begin
               fixed[4*g+2] = fixed[4*g+2] ^ syn_i[4*g+1];
               fixed[4*g+1] = fixed[4*g+1] ^ syn_i[4*g];
            end
            default: ;
         endcase
      end
      cw_o     = {chk_field(fixed), fixed};
      corr_o   = (region != REG_NONE);
      uncorr_o = mode_i && (|syn_i) && (region == REG_NONE);
   end

endmodule

// File: rtl/ecc_diag_codec_pipe.sv
// rtl/ecc_diag_codec_pipe.sv - two-stage multi-lane diagonal-parity encode/scrub pipe; ECC_DIAG_ERR_INJECT_EN adds inj_mask
module ecc_diag_codec_pipe
   import ecc_diag_pkg::*;
#(
   parameter int NUM_WORDS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_mode,
   input  logic [NUM_WORDS*CW_W-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_WORDS*CW_W-1:0] out_data,
   output logic [NUM_WORDS-1:0]      out_corr,
   output logic [NUM_WORDS-1:0]      out_uncorr,
   input  logic                      cnt_clr,
   output logic [CNT_W-1:0]          corr_cnt,
   output logic [CNT_W-1:0]          uncorr_cnt
`ifdef ECC_DIAG_ERR_INJECT_EN
   ,
   input  logic [NUM_WORDS*CW_W-1:0] inj_mask
`endif
);

   localparam int               SUM_W   = CNT_W + $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                             adv1, adv2;
   logic                             s1_valid_q, s2_valid_q, s1_mode_q;
   logic [NUM_WORDS-1:0][DATA_W-1:0] s1_data_q;
   logic [NUM_WORDS-1:0][CHK_W-1:0]  syn_d, s1_syn_q;
   logic [NUM_WORDS-1:0][2:0]        ta_d, tb_d, tc_d, s1_ta_q, s1_tb_q, s1_tc_q;
   logic [NUM_WORDS*CW_W-1:0]        cw_d, s2_data_d, out_data_q;
   logic [NUM_WORDS-1:0]             corr_d, uncorr_d, out_corr_q, out_uncorr_q;
   logic [CNT_W-1:0]                 corr_cnt_q, uncorr_cnt_q, corr_cnt_d, uncorr_cnt_d;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [NUM_WORDS-1:0] flags);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(cnt);
      for (int w = 0; w < NUM_WORDS; w++)
         sum = sum + SUM_W'(flags[w]);
      return (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
   endfunction

   assign adv2       = !s2_valid_q || out_ready;
   assign adv1       = !s1_valid_q || adv2;
   assign in_ready   = adv1;
   assign out_valid  = s2_valid_q;
   assign out_data   = out_data_q;
   assign out_corr   = out_corr_q;
   assign out_uncorr = out_uncorr_q;
   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_lane
      ecc_diag_lane u_lane (
         .cw_i     (in_data[w*CW_W +: CW_W]),
         .syn_o    (syn_d[w]),
         .ta_o     (ta_d[w]),
         .tb_o     (tb_d[w]),
         .tc_o     (tc_d[w]),
         .mode_i   (s1_mode_q),
         .data_i   (s1_data_q[w]),
         .syn_i    (s1_syn_q[w]),
         .ta_i     (s1_ta_q[w]),
         .tb_i     (s1_tb_q[w]),
         .tc_i     (s1_tc_q[w]),
         .cw_o     (cw_d[w*CW_W +: CW_W]),
         .corr_o   (corr_d[w]),
         .uncorr_o (uncorr_d[w])
      );
   end

`ifdef ECC_DIAG_ERR_INJECT_EN
   logic [NUM_WORDS*CW_W-1:0] s1_inj_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         s1_inj_q <= '0;
      else if (in_valid && adv1)
         s1_inj_q <= inj_mask;
   end

   assign s2_data_d = s1_mode_q ? cw_d : (cw_d ^ s1_inj_q);
`else
   assign s2_data_d = cw_d;
`endif

   // A clear in the same cycle as an output handshake drops that beat's increments.
   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (cnt_clr) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (s2_valid_q && out_ready) begin
         corr_cnt_d   = sat_add(corr_cnt_q, out_corr_q);
         uncorr_cnt_d = sat_add(uncorr_cnt_q, out_uncorr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s1_mode_q    <= 1'b0;
         s1_data_q    <= '0;
         s1_syn_q     <= '0;
         s1_ta_q      <= '0;
         s1_tb_q      <= '0;
         s1_tc_q      <= '0;
         out_data_q   <= '0;
         out_corr_q   <= '0;
         out_uncorr_q <= '0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         if (adv1)
            s1_valid_q <= in_valid;
         if (in_valid && adv1) begin
            s1_mode_q <= in_mode;
            s1_syn_q  <= syn_d;
            s1_ta_q   <= ta_d;
            s1_tb_q   <= tb_d;
            s1_tc_q   <= tc_d;
            for (int w = 0; w < NUM_WORDS; w++)
               s1_data_q[w] <= in_data[w*CW_W +: DATA_W];
         end
         if (adv2)
            s2_valid_q <= s1_valid_q;
         if (s1_valid_q && adv2) begin
            out_data_q   <= s2_data_d;
            out_corr_q   <= corr_d;
            out_uncorr_q <= uncorr_d;
         end
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

endmodule

// File: tb/tb_ecc_diag_codec_pipe.sv
// tb/tb_ecc_diag_codec_pipe.sv - randomized self-checking bench for ecc_diag_codec_pipe against a tap-mask code model
module tb_ecc_diag_codec_pipe;

   localparam int NW = 4;
   localparam int W  = NW * 34;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_mode, out_ready, cnt_clr;
   logic [W-1:0]  in_data;
   logic          in_ready, out_valid, in_ready_s, out_valid_s;
   logic [W-1:0]  out_data, out_data_s;
   logic [NW-1:0] out_corr, out_uncorr, out_corr_s, out_uncorr_s;
   logic [15:0]   corr_cnt, uncorr_cnt;
   logic [1:0]    corr_cnt_s, uncorr_cnt_s;

   typedef struct {
      logic [W-1:0]  data;
      logic [NW-1:0] corr;
      logic [NW-1:0] uncorr;
   } beat_t;

   beat_t exp_q[$];
   int    passed = 0;
   int    total  = 0;
   int    cnt_c  = 0;
   int    cnt_u  = 0;

   always #5 clk = ~clk;

   ecc_diag_codec_pipe #(.NUM_WORDS(NW), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_corr(out_corr), .out_uncorr(out_uncorr), .cnt_clr(cnt_clr),
      .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   ecc_diag_codec_pipe #(.NUM_WORDS(NW), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_mode(in_mode),
      .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_corr(out_corr_s), .out_uncorr(out_uncorr_s), .cnt_clr(cnt_clr),
      .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s)
   );

   function automatic logic [15:0] m_e(input int g, input int k);
      return 16'(1) << (4*g + 4 - k);
   endfunction

   // Each check bit is the parity of the data bits selected by its tap mask.
   function automatic logic [17:0] m_chk(input logic [15:0] d);
      logic [15:0] tap [18];
      logic [17:0] c;
      for (int g = 0; g < 4; g++) begin
         tap[4*g]   = m_e(g, 2) | m_e(g, 4);
         tap[4*g+1] = m_e(g, 1) | m_e(g, 3);
         tap[4*g+2] = m_e(0, g+1) | m_e(1, g+1) | m_e(2, g+1) | m_e(3, g+1);
      end
      tap[3]  = m_e(0, 1) | m_e(1, 2) | m_e(2, 1) | m_e(3, 2);
      tap[7]  = m_e(1, 1) | m_e(0, 2) | m_e(2, 2) | m_e(3, 1);
      tap[11] = m_e(0, 3) | m_e(1, 4) | m_e(2, 3) | m_e(3, 4);
      tap[15] = m_e(1, 3) | m_e(0, 4) | m_e(2, 4) | m_e(3, 3);
      tap[16] = m_e(0, 2) | m_e(1, 3) | m_e(2, 2) | m_e(3, 3);
      tap[17] = m_e(1, 2) | m_e(0, 3) | m_e(2, 3) | m_e(3, 2);
      for (int i = 0; i < 18; i++)
         c[i] = ^(d & tap[i]);
      return c;
   endfunction

   function automatic beat_t m_beat(input logic mode, input logic [W-1:0] din);
      beat_t b;
      for (int w = 0; w < NW; w++) begin
         logic [33:0] cw;
         logic [15:0] d;
         logic [17:0] s;
         int          ta, tb, tc, r, ka;
         cw = din[w*34 +: 34];
         d  = cw[15:0];
         s  = cw[33:16] ^ m_chk(d);
         ta = $countones({s[3], s[7], s[2], s[6]});
         tb = $countones({s[11], s[15], s[10], s[14]});
         tc = $countones({s[16], s[17], s[6], s[10]});
         r  = 0;
         if (ta > tb && ta > tc)      r = 1;
         else if (tb > ta && tb > tc) r = 2;
         else if (tc > ta && tc > tb) r = 3;
         if (!mode) begin
            r = 0;
            s = '0;
         end
         ka = (r == 1) ? 1 : (r == 2) ? 3 : 2;
         for (int g = 0; g < 4; g++) begin
            if (r != 0 && s[4*g+1]) d = d ^ m_e(g, ka);
            if (r != 0 && s[4*g])   d = d ^ m_e(g, ka + 1);
         end
         b.data[w*34 +: 34] = {m_chk(d), d};
         b.corr[w]          = (r != 0);
         b.uncorr[w]        = mode && (s != 0) && (r == 0);
      end
      return b;
   endfunction

   function automatic logic [W-1:0] rand_beat();
      logic [W-1:0] v;
      for (int w = 0; w < NW; w++) begin
         logic [15:0] d;
         logic [33:0] cw;
         int          idx;
         d  = 16'($urandom);
         cw = {m_chk(d), d};
         for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
            idx     = int'($urandom_range(0, 33));
            cw[idx] = ~cw[idx];
         end
         v[w*34 +: 34] = cw;
      end
      return v;
   endfunction

   task automatic send_one(input logic mode, input logic [W-1:0] din, output beat_t got, output int lat);
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = mode;
      in_data   = din;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = -1;
      for (int c = 1; c <= 10 && lat < 0; c++) begin
         if (out_valid) lat = c;
         else begin
            @(posedge clk); #1;
         end
      end
      got.data   = out_data;
      got.corr   = out_corr;
      got.uncorr = out_uncorr;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
      total++; if (out_data !== '0) $display("FAIL reset_out_data got %h exp 0", out_data); else passed++;
      total++; if ({out_corr, out_uncorr} !== '0) $display("FAIL reset_flags got %b exp 0", {out_corr, out_uncorr}); else passed++;
      total++; if ({corr_cnt, uncorr_cnt} !== '0) $display("FAIL reset_counters got %h exp 0", {corr_cnt, uncorr_cnt}); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
   endtask

   task automatic test_encode();
      beat_t        got;
      int           lat;
      logic [W-1:0] din;
      for (int w = 0; w < NW; w++)
         din[w*34 +: 34] = {18'($urandom), 16'h0001};
      send_one(1'b0, din, got, lat);
      total++; if (lat !== 2) $display("FAIL encode_latency got %0d exp 2", lat); else passed++;
      total++; if (got.data !== {NW{34'h0_C001_0001}}) $display("FAIL encode_data got %h exp %h", got.data, {NW{34'h0_C001_0001}}); else passed++;
      total++; if ({got.corr, got.uncorr} !== '0) $display("FAIL encode_flags got %b exp 0", {got.corr, got.uncorr}); else passed++;
   endtask

   task automatic test_decode_clean();
      beat_t got;
      int    lat;
      send_one(1'b1, {NW{34'h0_C001_0001}}, got, lat);
      total++; if (got.data !== {NW{34'h0_C001_0001}}) $display("FAIL clean_data got %h exp %h", got.data, {NW{34'h0_C001_0001}}); else passed++;
      total++; if ({got.corr, got.uncorr} !== '0) $display("FAIL clean_flags got %b exp 0", {got.corr, got.uncorr}); else passed++;
      total++; if ({corr_cnt, uncorr_cnt} !== '0) $display("FAIL clean_counters got %h exp 0", {corr_cnt, uncorr_cnt}); else passed++;
   endtask

   task automatic test_decode_single();
      beat_t got;
      int    lat;
      send_one(1'b1, {34'h0_C001_0001, 34'h0, 34'h1, 34'h8}, got, lat);
      total++; if (lat !== 2) $display("FAIL single_latency got %0d exp 2", lat); else passed++;
      total++; if (got.data !== {34'h0_C001_0001, 34'h0, 34'h0, 34'h0}) $display("FAIL single_data got %h exp %h", got.data, {34'h0_C001_0001, 34'h0, 34'h0, 34'h0}); else passed++;
      total++; if (got.corr !== 4'b0011) $display("FAIL single_corr got %b exp 0011", got.corr); else passed++;
      total++; if (got.uncorr !== 4'b0000) $display("FAIL single_uncorr got %b exp 0000", got.uncorr); else passed++;
      total++; if (corr_cnt !== 16'd2) $display("FAIL single_corr_cnt got %0d exp 2", corr_cnt); else passed++;
      total++; if (corr_cnt_s !== 2'd2) $display("FAIL single_corr_cnt_w2 got %0d exp 2", corr_cnt_s); else passed++;
   endtask

   task automatic test_decode_tie();
      beat_t got;
      int    lat;
      send_one(1'b1, {34'h0, 34'h9, 34'h0, 34'h0}, got, lat);
      total++; if (got.data !== {34'h0, 34'h0_C00F_0009, 34'h0, 34'h0}) $display("FAIL tie_data got %h exp %h", got.data, {34'h0, 34'h0_C00F_0009, 34'h0, 34'h0}); else passed++;
      total++; if (got.corr !== 4'b0000) $display("FAIL tie_corr got %b exp 0000", got.corr); else passed++;
      total++; if (got.uncorr !== 4'b0100) $display("FAIL tie_uncorr got %b exp 0100", got.uncorr); else passed++;
      total++; if (uncorr_cnt !== 16'd1) $display("FAIL tie_uncorr_cnt got %0d exp 1", uncorr_cnt); else passed++;
      total++; if (corr_cnt !== 16'd2) $display("FAIL tie_corr_cnt got %0d exp 2", corr_cnt); else passed++;
   endtask

   task automatic test_saturation();
      beat_t got;
      int    lat;
      @(negedge clk);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      total++; if ({corr_cnt, uncorr_cnt, corr_cnt_s, uncorr_cnt_s} !== '0) $display("FAIL clr_counters got %h exp 0", {corr_cnt, uncorr_cnt, corr_cnt_s, uncorr_cnt_s}); else passed++;
      send_one(1'b1, {NW{34'h8}}, got, lat);
      send_one(1'b1, {34'h1, 34'h8, 34'h1, 34'h8}, got, lat);
      send_one(1'b1, {NW{34'h9}}, got, lat);
      total++; if (corr_cnt !== 16'd8) $display("FAIL sat_corr_w16 got %0d exp 8", corr_cnt); else passed++;
      total++; if (corr_cnt_s !== 2'd3) $display("FAIL sat_corr_w2 got %0d exp 3", corr_cnt_s); else passed++;
      total++; if (uncorr_cnt !== 16'd4) $display("FAIL sat_uncorr_w16 got %0d exp 4", uncorr_cnt); else passed++;
      total++; if (uncorr_cnt_s !== 2'd3) $display("FAIL sat_uncorr_w2 got %0d exp 3", uncorr_cnt_s); else passed++;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1; in_data = {NW{34'h1}};
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 10 && !out_valid; c++) begin
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b1) $display("FAIL clr_hs_valid got %b exp 1", out_valid); else passed++;
      @(negedge clk);
      cnt_clr = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      total++; if ({corr_cnt, uncorr_cnt} !== '0) $display("FAIL clr_hs_w16 got %h exp 0", {corr_cnt, uncorr_cnt}); else passed++;
      total++; if ({corr_cnt_s, uncorr_cnt_s} !== '0) $display("FAIL clr_hs_w2 got %h exp 0", {corr_cnt_s, uncorr_cnt_s}); else passed++;
   endtask

   task automatic test_stall_random();
      beat_t        e;
      logic [W-1:0] held;
      exp_q.delete();
      cnt_c = 0;
      cnt_u = 0;
      held  = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (cyc < 5) begin
            in_valid = 1'b1; out_ready = 1'b0;
         end else if (cyc < 260) begin
            in_valid = 1'($urandom_range(0, 1)); out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1;
         end
         in_mode = 1'($urandom_range(0, 1));
         in_data = rand_beat();
         cnt_clr = (cyc > 5) && ($urandom_range(0, 40) == 0);
         #1;
         total++; if (corr_cnt !== 16'(cnt_c > 65535 ? 65535 : cnt_c)) $display("FAIL rnd_corr_cnt cyc %0d got %0d exp %0d", cyc, corr_cnt, cnt_c); else passed++;
         total++; if (uncorr_cnt !== 16'(cnt_u > 65535 ? 65535 : cnt_u)) $display("FAIL rnd_uncorr_cnt cyc %0d got %0d exp %0d", cyc, uncorr_cnt, cnt_u); else passed++;
         total++; if (corr_cnt_s !== 2'(cnt_c > 3 ? 3 : cnt_c)) $display("FAIL rnd_corr_cnt_w2 cyc %0d got %0d exp %0d", cyc, corr_cnt_s, cnt_c > 3 ? 3 : cnt_c); else passed++;
         total++; if (uncorr_cnt_s !== 2'(cnt_u > 3 ? 3 : cnt_u)) $display("FAIL rnd_uncorr_cnt_w2 cyc %0d got %0d exp %0d", cyc, uncorr_cnt_s, cnt_u > 3 ? 3 : cnt_u); else passed++;
         if (cyc < 5) begin
            total++; if (in_ready !== (cyc < 2)) $display("FAIL stall_in_ready cyc %0d got %b exp %b", cyc, in_ready, cyc < 2); else passed++;
         end
         if (cyc == 2) held = out_data;
         if (cyc == 3 || cyc == 4) begin
            total++; if (out_data !== held) $display("FAIL stall_hold cyc %0d got %h exp %h", cyc, out_data, held); else passed++;
         end
         if (in_valid && in_ready) exp_q.push_back(m_beat(in_mode, in_data));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++; $display("FAIL rnd_extra_beat cyc %0d got beat %h exp none", cyc, out_data);
            end else begin
               e = exp_q.pop_front();
               total++; if (out_data !== e.data) $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, out_data, e.data); else passed++;
               total++; if (out_corr !== e.corr) $display("FAIL rnd_corr cyc %0d got %b exp %b", cyc, out_corr, e.corr); else passed++;
               total++; if (out_uncorr !== e.uncorr) $display("FAIL rnd_uncorr cyc %0d got %b exp %b", cyc, out_uncorr, e.uncorr); else passed++;
               if (!cnt_clr) begin
                  cnt_c += $countones(e.corr);
                  cnt_u += $countones(e.uncorr);
               end
            end
         end
         if (cnt_clr) begin
            cnt_c = 0;
            cnt_u = 0;
         end
      end
      cnt_clr = 1'b0;
      total++; if (exp_q.size() != 0) $display("FAIL rnd_lost_beats got %0d pending exp 0", exp_q.size()); else passed++;
   endtask

   task automatic test_reset_inflight();
      int seen;
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b1; in_data = rand_beat();
      @(negedge clk);
      in_data = rand_beat();
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) $display("FAIL inflight_valid got %b exp 1", out_valid); else passed++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) $display("FAIL inflight_rst_valid got %b exp 0", out_valid); else passed++;
      total++; if ({corr_cnt, uncorr_cnt, corr_cnt_s, uncorr_cnt_s} !== '0) $display("FAIL inflight_rst_cnt got %h exp 0", {corr_cnt, uncorr_cnt, corr_cnt_s, uncorr_cnt_s}); else passed++;
      total++; if (out_data !== '0) $display("FAIL inflight_rst_data got %h exp 0", out_data); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      total++; if (seen != 0) $display("FAIL inflight_stale got %0d beats exp 0", seen); else passed++;
   endtask

   initial begin
      test_reset();
      test_encode();
      test_decode_clean();
      test_decode_single();
      test_decode_tie();
      test_saturation();
      test_stall_random();
      test_reset_inflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
